// File: rtl/sparse_cfg_seq_pkg.sv
// Shared state encoding, bitstream word layout and default timing constants
// for the sparse tile array config sequencer.
package sparse_cfg_seq_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_CFG       = 4'd1;
  localparam state_t ST_CFG_DRAIN = 4'd2;
  localparam state_t ST_GAP       = 4'd3;
  localparam state_t ST_FLUSH_S   = 4'd4;
  localparam state_t ST_FLUSH_R   = 4'd5;
  localparam state_t ST_RUN       = 4'd6;
  localparam state_t ST_DONE      = 4'd7;
  localparam state_t ST_TIMEOUT   = 4'd8;
  localparam state_t ST_VERIFY    = 4'd9;
  localparam state_t ST_ERR       = 4'd10;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } bs_word_t;

  localparam int DEF_FLUSH_STALLED_CYC = 16;
  localparam int DEF_FLUSH_RUN_CYC     = 2;
  localparam int DEF_TIMEOUT_CYC       = 50000;

endpackage

// File: rtl/sparse_cfg_stream.sv
// Bitstream read sequencer: walks entries 0..n-1 one per cycle and flags the
// cycle each word is returned (read latency 1), plus the last-entry markers.
module sparse_cfg_stream
  import sparse_cfg_seq_pkg::*;
#(
  parameter int BS_AW = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             abort,
  input  logic [BS_AW:0]   go_n,
  output logic             rd_en,
  output logic [BS_AW-1:0] rd_addr,
  output logic             rd_last,
  output logic             out_vld,
  output logic             out_last
);

  logic             active_q, active_d;
  logic [BS_AW-1:0] idx_q, idx_d;
  logic [BS_AW:0]   last_q, last_d;
  logic             out_vld_q, out_vld_d;
  logic             out_last_q, out_last_d;

  assign rd_en    = active_q;
  assign rd_addr  = idx_q;
  assign rd_last  = active_q && ({1'b0, idx_q} == last_q);
  assign out_vld  = out_vld_q;
  assign out_last = out_last_q;

  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    last_d   = last_q;
    if (go) begin
      active_d = 1'b1;
      idx_d    = '0;
      last_d   = go_n - {{BS_AW{1'b0}}, 1'b1};
    end else if (abort || rd_last) begin
      active_d = 1'b0;
    end else if (active_q) begin
      idx_d = idx_q + {{(BS_AW-1){1'b0}}, 1'b1};
    end
    // A restart or abort discards the word still in flight from the old walk.
    out_vld_d  = rd_en && !go && !abort;
    out_last_d = rd_last && !go && !abort;
  end

  // Read-issue stage -> word-returned stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      idx_q      <= '0;
      last_q     <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      active_q   <= active_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
    end
  end

endmodule

// File: rtl/sparse_config_sequencer.sv
// Sparse tile array bring-up: streams the config bitstream, runs the flush/stall
// release, then times the run. Define SPARSE_CFG_READBACK_EN for config readback checking.
module sparse_config_sequencer
  import sparse_cfg_seq_pkg::*;
#(
  parameter int BS_DEPTH          = 4096,
  parameter int BS_AW             = $clog2(BS_DEPTH),
  parameter int FLUSH_STALLED_CYC = DEF_FLUSH_STALLED_CYC,
  parameter int FLUSH_RUN_CYC     = DEF_FLUSH_RUN_CYC,
  parameter int TIMEOUT_CYC       = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BS_AW:0]   bs_size,
  output logic             bs_rd_en,
  output logic [BS_AW-1:0] bs_rd_addr,
  input  logic [63:0]      bs_rd_data,
  output logic [31:0]      config_config_addr,
  output logic [31:0]      config_config_data,
  output logic             config_write,
  output logic             config_read,
`ifdef SPARSE_CFG_READBACK_EN
  input  logic [31:0]      config_rd_data,
  output logic             cfg_err,
`endif
  output logic             stall,
  output logic             flush,
  input  logic             dut_done,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [63:0]      cycle_count
);

  localparam int             NW       = BS_AW + 1;
  localparam logic [BS_AW:0] DEPTH_N  = NW'(BS_DEPTH);
  localparam logic [15:0]    FS_LAST  = 16'(FLUSH_STALLED_CYC - 1);
  localparam logic [15:0]    FR_LAST  = 16'(FLUSH_RUN_CYC - 1);
  localparam logic [63:0]    TO_LIMIT = 64'(TIMEOUT_CYC);

  function automatic logic [BS_AW:0] sat_size(input logic [BS_AW:0] sz);
    return (sz > DEPTH_N) ? DEPTH_N : sz;
  endfunction

  state_t         state_q, state_d;
  logic [BS_AW:0] n_q, n_d;
  logic [15:0]    ph_q, ph_d;
  logic [63:0]    cnt_q, cnt_d;
  logic [31:0]    cfg_addr_q, cfg_addr_d;
  logic [31:0]    cfg_data_q, cfg_data_d;

  logic           go, abort, idle_like;
  logic [BS_AW:0] go_n;
  logic           strm_rd_last, strm_vld, strm_last;
  bs_word_t       bs_word;

  assign bs_word = bs_rd_data;

  sparse_cfg_stream #(.BS_AW(BS_AW)) u_stream (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .abort    (abort),
    .go_n     (go_n),
    .rd_en    (bs_rd_en),
    .rd_addr  (bs_rd_addr),
    .rd_last  (strm_rd_last),
    .out_vld  (strm_vld),
    .out_last (strm_last)
  );

  assign config_write = strm_vld && (state_q == ST_CFG || state_q == ST_CFG_DRAIN);

`ifdef SPARSE_CFG_READBACK_EN
  logic        cmp_vld_q, cmp_vld_d;
  logic        cmp_last_q, cmp_last_d;
  logic [31:0] exp_q, exp_d;
  logic        rb_bad;

  assign config_read = strm_vld && (state_q == ST_VERIFY);
  assign rb_bad      = cmp_vld_q && (config_rd_data != exp_q);
  assign cfg_err     = (state_q == ST_ERR);

  always_comb begin
    cmp_vld_d  = config_read;
    cmp_last_d = config_read && strm_last;
    exp_d      = config_read ? bs_word.data : exp_q;
  end

  // Readback issue stage -> compare stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_vld_q  <= 1'b0;
      cmp_last_q <= 1'b0;
      exp_q      <= '0;
    end else begin
      cmp_vld_q  <= cmp_vld_d;
      cmp_last_q <= cmp_last_d;
      exp_q      <= exp_d;
    end
  end

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                     (state_q == ST_TIMEOUT) || (state_q == ST_ERR);
`else
  assign config_read = 1'b0;
  assign idle_like   = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                       (state_q == ST_TIMEOUT);
`endif

  // The bus shows the returned word in its write cycle and holds it afterwards.
  always_comb begin
    cfg_addr_d = (config_write || config_read) ? bs_word.addr : cfg_addr_q;
    cfg_data_d = config_write ? bs_word.data : cfg_data_q;
  end

  assign config_config_addr = cfg_addr_d;
  assign config_config_data = cfg_data_d;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    go      = 1'b0;
    abort   = 1'b0;
    go_n    = n_q;
    if (idle_like) begin
      if (start) begin
        n_d   = sat_size(bs_size);
        cnt_d = '0;
        if (n_d != '0) begin
          state_d = ST_CFG;
          go      = 1'b1;
          go_n    = n_d;
        end else begin
          state_d = ST_GAP;
        end
      end
    end else begin
      case (state_q)
        ST_CFG: if (strm_rd_last) state_d = ST_CFG_DRAIN;
        ST_CFG_DRAIN: begin
          if (strm_last) begin
`ifdef SPARSE_CFG_READBACK_EN
            state_d = ST_VERIFY;
            go      = 1'b1;
`else
            state_d = ST_GAP;
`endif
          end
        end
`ifdef SPARSE_CFG_READBACK_EN
        ST_VERIFY: begin
          if (rb_bad) begin
            state_d = ST_ERR;
            abort   = 1'b1;
          end else if (cmp_vld_q && cmp_last_q) begin
            state_d = ST_GAP;
          end
        end
`endif
        ST_GAP: begin
          state_d = ST_FLUSH_S;
          ph_d    = '0;
        end
        ST_FLUSH_S: begin
          ph_d = ph_q + 16'd1;
          if (ph_q == FS_LAST) begin
            state_d = ST_FLUSH_R;
            ph_d    = '0;
          end
        end
        ST_FLUSH_R: begin
          ph_d = ph_q + 16'd1;
          if (ph_q == FR_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          // Completion beats a simultaneous timeout; the done cycle is not counted.
          if (dut_done) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 64'd1;
            if (cnt_d == TO_LIMIT) state_d = ST_TIMEOUT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      ph_q       <= '0;
      cnt_q      <= '0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
    end
  end

  assign busy        = !idle_like;
  assign flush       = (state_q == ST_FLUSH_S) || (state_q == ST_FLUSH_R);
  assign stall       = !((state_q == ST_FLUSH_R) || (state_q == ST_RUN));
  assign done        = (state_q == ST_DONE);
  assign timeout     = (state_q == ST_TIMEOUT);
  assign cycle_count = cnt_q;

endmodule
